// File: rtl/ad9866_pkg.sv
// Shared types and constants for the AD9866 serial-port sequencer.
package ad9866_pkg;

   typedef enum logic [2:0] {
      ST_HRST,
      ST_HWAIT,
      ST_INIT,
      ST_SHIFT,
      ST_GAP,
      ST_IDLE
   } state_t;

   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 8;
   localparam int FRAME_W = 16;
   localparam int GAIN_W  = 6;

   localparam int INIT_LEN = 8;
   localparam logic [ADDR_W-1:0] GAIN_ADDR_DEF = 5'h09;

   localparam logic [FRAME_W-1:0] INIT_TABLE [INIT_LEN] = '{
      16'h0080, 16'h0100, 16'h0216, 16'h0341,
      16'h0401, 16'h0581, 16'h0742, 16'h0820
   };

   // Frame layout on the wire, MSB first: rw, two zero bits, address, data.
   function automatic logic [FRAME_W-1:0] mk_frame(input logic rw,
                                                   input logic [ADDR_W-1:0] addr,
                                                   input logic [DATA_W-1:0] data);
      return {rw, 2'b00, addr, data};
   endfunction

endpackage

// File: rtl/ad9866_spi_shift.sv
// 16-bit SPI shifter with SCLK divider; one load strobe in, one done strobe out.
module ad9866_spi_shift
   import ad9866_pkg::*;
#(
   parameter int SPI_DIV = 4
) (
   input  logic               ad9866spiclk,
   input  logic               reset,
   input  logic               i_load,
   input  logic [FRAME_W-1:0] i_frame,
   input  logic               i_rd,
   input  logic               i_sdo,
   output logic               o_sclk,
   output logic               o_sdio,
   output logic               o_sen_n,
   output logic               o_done,
   output logic [DATA_W-1:0]  o_rd_byte
);

   localparam int DIV_W = $clog2(SPI_DIV);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SPI_DIV - 1);

   logic               r_active;
   logic [DIV_W-1:0]   r_div;
   logic [3:0]         r_bit;
   logic [FRAME_W-1:0] r_sr;
   logic               r_rd;
   logic [DATA_W-1:0]  r_rd_sr;
   logic [DATA_W-1:0]  r_rd_byte;
   logic               r_sclk;
   logic               r_sdio;
   logic               r_sen_n;
   logic               r_done;

   always_ff @(posedge ad9866spiclk) begin
      if (reset) begin
         r_active  <= 1'b0;
         r_div     <= '0;
         r_bit     <= '0;
         r_sr      <= '0;
         r_rd      <= 1'b0;
         r_rd_sr   <= '0;
         r_rd_byte <= '0;
         r_sclk    <= 1'b0;
         r_sdio    <= 1'b0;
         r_sen_n   <= 1'b1;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_load) begin
            r_active <= 1'b1;
            r_sen_n  <= 1'b0;
            r_sclk   <= 1'b0;
            r_sdio   <= i_frame[FRAME_W-1];
            r_sr     <= i_frame;
            r_bit    <= 4'd15;
            r_div    <= DIV_MAX;
            r_rd     <= i_rd;
         end else if (r_active) begin
            if (r_div != '0) begin
               r_div <= r_div - 1'b1;
            end else begin
               r_div <= DIV_MAX;
               if (!r_sclk) begin
                  r_sclk <= 1'b1;
                  // data byte of a read: capture sdo as sclk rises
                  if (r_rd && (r_bit < 4'd8))
                     r_rd_sr <= {r_rd_sr[DATA_W-2:0], i_sdo};
               end else if (r_bit == 4'd0) begin
                  r_active <= 1'b0;
                  r_sclk   <= 1'b0;
                  r_sen_n  <= 1'b1;
                  r_done   <= 1'b1;
                  if (r_rd)
                     r_rd_byte <= r_rd_sr;
               end else begin
                  r_sclk <= 1'b0;
                  r_bit  <= r_bit - 4'd1;
                  r_sdio <= r_sr[FRAME_W-2];
                  r_sr   <= {r_sr[FRAME_W-2:0], 1'b0};
               end
            end
         end
      end
   end

   assign o_sclk    = r_sclk;
   assign o_sdio    = r_sdio;
   assign o_sen_n   = r_sen_n;
   assign o_done    = r_done;
   assign o_rd_byte = r_rd_byte;

endmodule

// File: rtl/ad9866_spi_ctrl.sv
// AD9866 configuration sequencer: hardware reset, init table replay, host/gain write arbitration.
// Define AD9866_READBACK_EN to honour cmd_rw and capture register readback.
//
// state    | meaning
// ST_HRST  | ad9866_rst_n held low for RST_CYCLES
// ST_HWAIT | reset released, wait RST_CYCLES
// ST_INIT  | load init table word idx into the shifter
// ST_SHIFT | frame on the wire
// ST_GAP   | sen_n high for 2*SPI_DIV, then next init word or idle
// ST_IDLE  | arbitrate host command vs. pending gain write
module ad9866_spi_ctrl
   import ad9866_pkg::*;
#(
   parameter int                SPI_DIV    = 4,
   parameter int                RST_CYCLES = 64,
   parameter logic [ADDR_W-1:0] GAIN_ADDR  = GAIN_ADDR_DEF
) (
   input  logic              ad9866spiclk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rw,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [GAIN_W-1:0] gain,
   output logic              init_done,
   output logic              busy,
   output logic              ad9866_sclk,
   output logic              ad9866_sdio,
   input  logic              ad9866_sdo,
   output logic              ad9866_sen_n,
   output logic              ad9866_rst_n,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid
);

   localparam int TMR_W = 16;
   localparam int IDX_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

   state_t             r_state;
   state_t             w_next;
   logic [TMR_W-1:0]   r_tmr;
   logic [IDX_W-1:0]   r_idx;
   logic               r_init_done;
   logic [GAIN_W-1:0]  r_sent_gain;
   logic               r_gain_pend;
   logic [1:0]         r_streak;

   logic               w_load;
   logic [FRAME_W-1:0] w_frame;
   logic               w_frame_rd;
   logic               w_host_acc;
   logic               w_gain_sel;
   logic               w_cmd_ready;
   logic               w_host_rw;
   logic               w_sdo_in;
   logic               w_done;
   logic [DATA_W-1:0]  w_rd_byte;
   logic               w_tmr_tc;

   assign w_tmr_tc = (r_tmr == '0);

   always_comb begin
      w_next      = r_state;
      w_load      = 1'b0;
      w_frame     = INIT_TABLE[r_idx];
      w_frame_rd  = 1'b0;
      w_host_acc  = 1'b0;
      w_gain_sel  = 1'b0;
      w_cmd_ready = 1'b0;
      case (r_state)
         ST_HRST:  if (w_tmr_tc) w_next = ST_HWAIT;
         ST_HWAIT: if (w_tmr_tc) w_next = ST_INIT;
         ST_INIT: begin
            w_load = 1'b1;
            w_next = ST_SHIFT;
         end
         ST_SHIFT: if (w_done) w_next = ST_GAP;
         ST_GAP: begin
            if (w_tmr_tc) begin
               if (!r_init_done && (r_idx != IDX_W'(INIT_LEN - 1)))
                  w_next = ST_INIT;
               else
                  w_next = ST_IDLE;
            end
         end
         ST_IDLE: begin
            // a pending gain write gets a turn after two back-to-back host writes
            w_cmd_ready = r_init_done && !(r_gain_pend && (r_streak == 2'd2));
            if (cmd_valid && w_cmd_ready) begin
               w_host_acc = 1'b1;
               w_load     = 1'b1;
               w_frame    = mk_frame(w_host_rw, cmd_addr, cmd_data);
               w_frame_rd = w_host_rw;
               w_next     = ST_SHIFT;
            end else if (r_init_done && r_gain_pend) begin
               w_gain_sel = 1'b1;
               w_load     = 1'b1;
               w_frame    = mk_frame(1'b0, GAIN_ADDR, {2'b01, gain});
               w_next     = ST_SHIFT;
            end
         end
         default: w_next = ST_HRST;
      endcase
   end

   always_ff @(posedge ad9866spiclk) begin
      if (reset) begin
         r_state     <= ST_HRST;
         r_tmr       <= TMR_W'(RST_CYCLES - 1);
         r_idx       <= '0;
         r_init_done <= 1'b0;
         r_sent_gain <= 6'h3F;
         r_gain_pend <= 1'b0;
         r_streak    <= 2'd0;
      end else begin
         r_state     <= w_next;
         r_gain_pend <= (gain != r_sent_gain);
         if (w_next != r_state) begin
            case (w_next)
               ST_HWAIT: r_tmr <= TMR_W'(RST_CYCLES - 1);
               ST_GAP:   r_tmr <= TMR_W'(2 * SPI_DIV - 1);
               default:  r_tmr <= '0;
            endcase
         end else if (!w_tmr_tc) begin
            r_tmr <= r_tmr - 1'b1;
         end
         if (r_state == ST_HWAIT)
            r_idx <= '0;
         else if ((r_state == ST_GAP) && (w_next == ST_INIT))
            r_idx <= r_idx + 1'b1;
         if ((r_state == ST_GAP) && (w_next == ST_IDLE))
            r_init_done <= 1'b1;
         if (w_host_acc) begin
            r_streak <= (r_streak == 2'd2) ? 2'd2 : r_streak + 2'd1;
         end else if (w_gain_sel) begin
            r_streak    <= 2'd0;
            r_sent_gain <= gain;
         end
      end
   end

   ad9866_spi_shift #(
      .SPI_DIV (SPI_DIV)
   ) u_shift (
      .ad9866spiclk (ad9866spiclk),
      .reset        (reset),
      .i_load       (w_load),
      .i_frame      (w_frame),
      .i_rd         (w_frame_rd),
      .i_sdo        (w_sdo_in),
      .o_sclk       (ad9866_sclk),
      .o_sdio       (ad9866_sdio),
      .o_sen_n      (ad9866_sen_n),
      .o_done       (w_done),
      .o_rd_byte    (w_rd_byte)
   );

`ifdef AD9866_READBACK_EN
   logic r_rd_frame;

   always_ff @(posedge ad9866spiclk) begin
      if (reset)
         r_rd_frame <= 1'b0;
      else if (w_load)
         r_rd_frame <= w_frame_rd;
   end

   assign w_host_rw = cmd_rw;
   assign w_sdo_in  = ad9866_sdo;
   assign rd_data   = w_rd_byte;
   assign rd_valid  = w_done & r_rd_frame;
`else
   logic w_unused;

   assign w_host_rw = 1'b0;
   assign w_sdo_in  = 1'b0;
   assign rd_data   = '0;
   assign rd_valid  = 1'b0;
   assign w_unused  = ^{cmd_rw, ad9866_sdo, w_rd_byte};
`endif

   assign cmd_ready    = w_cmd_ready;
   assign init_done    = r_init_done;
   assign busy         = !((r_state == ST_IDLE) && r_init_done);
   assign ad9866_rst_n = (r_state != ST_HRST);

endmodule

// File: tb/tb_ad9866_spi_ctrl.sv
// Self-checking bench for ad9866_spi_ctrl: SPI frames captured off the pins and matched against a scoreboard.
module tb_ad9866_spi_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_rw;
   logic [4:0] cmd_addr;
   logic [7:0] cmd_data;
   logic [5:0] gain;
   logic       init_done;
   logic       busy;
   logic       sclk;
   logic       sdio;
   logic       sdo;
   logic       sen_n;
   logic       rst_n;
   logic [7:0] rd_data;
   logic       rd_valid;

   ad9866_spi_ctrl dut (
      .ad9866spiclk (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_rw       (cmd_rw),
      .cmd_addr     (cmd_addr),
      .cmd_data     (cmd_data),
      .gain         (gain),
      .init_done    (init_done),
      .busy         (busy),
      .ad9866_sclk  (sclk),
      .ad9866_sdio  (sdio),
      .ad9866_sdo   (sdo),
      .ad9866_sen_n (sen_n),
      .ad9866_rst_n (rst_n),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rw;
      logic [4:0]  addr;
      logic [7:0]  data;
      logic [15:0] exp;
   } vec_t;

   localparam logic [15:0] INIT_TAB [8] = '{
      16'h0080, 16'h0100, 16'h0216, 16'h0341,
      16'h0401, 16'h0581, 16'h0742, 16'h0820
   };

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [15:0] sb_q [$];

   int          frames_seen = 0;
   int          frame_end_cyc = 0;
   int          bits_seen = 0;
   int          low_cnt = 0;
   int          rd_valid_cnt = 0;
   logic [15:0] shreg = '0;
   logic [15:0] sdo_word = '0;
   logic        prev_sen_n = 1'b1;
   logic        prev_sclk = 1'b0;
   logic        last_rd_valid = 1'b0;
   logic [7:0]  last_rd_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   // Pin monitor: rebuilds each frame, drives sdo for reads, pops the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         prev_sen_n = 1'b1;
         prev_sclk  = 1'b0;
         bits_seen  = 0;
         low_cnt    = 0;
         shreg      = '0;
         sdo        = 1'b0;
      end else begin
         if (rd_valid) rd_valid_cnt++;
         if (!sen_n) begin
            low_cnt++;
            if (sclk && !prev_sclk) begin
               shreg = {shreg[14:0], sdio};
               bits_seen++;
            end
            sdo = (bits_seen < 16) ? sdo_word[15 - bits_seen] : 1'b0;
         end else if (!prev_sen_n) begin
            check("sclk_at_sen_rise", 32'(sclk), 32'd0);
            check("frame_len", 32'(low_cnt * 1000 + bits_seen), 32'(128 * 1000 + 16));
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL frame_unexpected: got %04h, expected no frame", shreg);
            end else begin
               check("frame_data", 32'(shreg), 32'(sb_q.pop_front()));
            end
            last_rd_valid = rd_valid;
            last_rd_data  = rd_data;
            frames_seen++;
            frame_end_cyc = cyc;
            bits_seen = 0;
            low_cnt   = 0;
            sdo       = 1'b0;
         end
         prev_sen_n = sen_n;
         prev_sclk  = sclk;
      end
   end

   task automatic wait_quiet();
      int n = 0;
      while ((busy || sb_q.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("quiet_timeout", 32'(n < 3000), 32'd1);
   endtask

   task automatic power_up(input bit with_host);
      int  n;
      int  f0;
      bit  early = 0;
      foreach (INIT_TAB[i]) sb_q.push_back(INIT_TAB[i]);
      if (with_host) sb_q.push_back(16'h0C3C);
      f0 = frames_seen;
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      while (rst_n === 1'b0 && n < 1000) begin
         n++;
         @(negedge clk);
      end
      check("rst_low_cycles", 32'(n), 32'd64);
      // release wait plus the table-load cycle before sen_n falls
      n = 0;
      while (sen_n === 1'b1 && n < 1000) begin
         n++;
         @(negedge clk);
      end
      check("rst_wait_cycles", 32'(n), 32'd65);
      n = 0;
      while (!init_done && n < 5000) begin
         if (cmd_ready || !busy) early = 1;
         n++;
         @(negedge clk);
      end
      check("init_done_seen", 32'(init_done), 32'd1);
      check("ready_held_off", 32'(early), 32'd0);
      check("init_frames", 32'(frames_seen - f0), 32'd8);
      check("init_gap", 32'(cyc - frame_end_cyc), 32'd9);
      check("idle_ready", 32'(cmd_ready), 32'd1);
      if (with_host) begin
         @(posedge clk);
         #1 cmd_valid = 1'b0;
      end
      wait_quiet();
   endtask

   task automatic host_write(input logic rw, input logic [4:0] a, input logic [7:0] d,
                             input logic [15:0] exp);
      int n = 0;
      while (!cmd_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 32'(n < 2000), 32'd1);
      cmd_rw = rw; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
      sb_q.push_back(exp);
      @(posedge clk);
      #1 cmd_valid = 1'b0; cmd_rw = 1'b0;
      @(negedge clk);
      check("ready_drop", 32'(cmd_ready), 32'd0);
      // frame, done cycle and gap must all pass before ready returns
      n = 0;
      while (!cmd_ready && n < 1000) begin
         n++;
         @(negedge clk);
      end
      check("ready_low_cycles", 32'(n), 32'd137);
   endtask

   vec_t vecs [4];

   initial begin
      int n;
      int f0;
      vecs[0] = '{1'b0, 5'h03, 8'hA5, 16'h03A5};
      vecs[1] = '{1'b0, 5'h1F, 8'h00, 16'h1F00};
      vecs[2] = '{1'b0, 5'h10, 8'hFF, 16'h10FF};
      vecs[3] = '{1'b0, 5'h00, 8'h5A, 16'h005A};

      reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_data = '0;
      gain = 6'h3F;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs",
            32'({sclk, sdio, sen_n, rst_n, init_done, busy, cmd_ready, rd_valid, rd_data}),
            32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}));

      power_up(1'b0);

      for (int i = 0; i < 4; i++)
         host_write(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].exp);
      wait_quiet();

      // gain changes inside one frame coalesce to the latest value
      f0 = frames_seen;
      gain = 6'h20;
      sb_q.push_back(16'h0960);
      n = 0;
      while (sen_n && n < 100) begin @(negedge clk); n++; end
      check("gain_frame_start", 32'(sen_n), 32'd0);
      repeat (20) @(negedge clk);
      gain = 6'h25;
      repeat (20) @(negedge clk);
      gain = 6'h21;
      sb_q.push_back(16'h0961);
      wait_quiet();
      repeat (300) @(negedge clk);
      check("gain_frame_count", 32'(frames_seen - f0), 32'd2);

      // host held valid with a pending gain: host, host, gain, host
      sb_q.push_back(16'h0411);
      sb_q.push_back(16'h0522);
      sb_q.push_back(16'h0955);
      sb_q.push_back(16'h0633);
      gain = 6'h15;
      cmd_addr = 5'h04; cmd_data = 8'h11; cmd_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
         check("arb_ready_wait", 32'(n < 2000), 32'd1);
         @(posedge clk);
         #1;
         if (k == 0) begin cmd_addr = 5'h05; cmd_data = 8'h22; end
         else if (k == 1) begin cmd_addr = 5'h06; cmd_data = 8'h33; end
         else cmd_valid = 1'b0;
         @(negedge clk);
      end
      wait_quiet();

      // register read of address 1 with the part returning 0x5C
      sdo_word = 16'h005C;
`ifdef AD9866_READBACK_EN
      host_write(1'b1, 5'h01, 8'h00, 16'h8100);
      check("rd_valid_at_end", 32'(last_rd_valid), 32'd1);
      check("rd_data_at_end", 32'(last_rd_data), 32'h5C);
      check("rd_data_held", 32'(rd_data), 32'h5C);
`else
      host_write(1'b1, 5'h01, 8'h00, 16'h0100);
      check("rd_valid_at_end", 32'(last_rd_valid), 32'd0);
      check("rd_data_zero", 32'(rd_data), 32'h00);
`endif
      sdo_word = '0;
      wait_quiet();

      // reset in the middle of a frame, then a host request held during the replayed init
      n = 0;
      while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
      cmd_addr = 5'h0A; cmd_data = 8'hC3; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      n = 0;
      while (bits_seen < 8 && n < 400) begin @(negedge clk); n++; end
      check("mid_frame_reached", 32'(bits_seen >= 8), 32'd1);
      reset = 1'b1;
      sb_q.delete();
      @(negedge clk);
      check("abort_pins", 32'({sen_n, sclk, rst_n, init_done, busy}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1}));
      repeat (3) @(negedge clk);
      cmd_addr = 5'h0C; cmd_data = 8'h3C; cmd_valid = 1'b1;
      power_up(1'b1);

`ifdef AD9866_READBACK_EN
      check("rd_valid_cycles", 32'(rd_valid_cnt), 32'd1);
`else
      check("rd_valid_cycles", 32'(rd_valid_cnt), 32'd0);
`endif
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
